// File: rtl/kf8237_acknowledge_controller_pkg.sv
// Shared types for the 8237 grant path: transfer modes, acknowledge FSM states,
// and the one-hot to channel index helper.
package kf8237_acknowledge_controller_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    DEMAND  = 2'b00,
    SINGLE  = 2'b01,
    BLOCK   = 2'b10,
    CASCADE = 2'b11
  } transfer_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE,
    RELEASE
  } ack_state_t;

  // Lowest set bit wins, so a malformed multi-hot request still maps to one channel.
  function automatic logic [1:0] onehot_to_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (v[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/kf8237_acknowledge_controller_if.sv
// Bus bundle between the priority encoder / CPU side and the acknowledge controller.
interface kf8237_acknowledge_controller_if;
  import kf8237_acknowledge_controller_pkg::*;

  logic [7:0]           internal_data_bus;
  logic                 write_command_register;
  logic                 master_clear;
  transfer_mode_t [3:0] transfer_mode;
  logic [3:0]           encoded_dma;
  logic [3:0]           dma_request_pending;
  logic                 cycle_done;
  logic                 end_of_process;
  logic                 hold_acknowledge;
  logic                 hold_request;
  logic [3:0]           dma_acknowledge_internal;
  logic [3:0]           dma_acknowledge;
  logic [1:0]           dma_rotate;
  logic                 service_start;

  modport master (
    output internal_data_bus, write_command_register, master_clear, transfer_mode,
           encoded_dma, dma_request_pending, cycle_done, end_of_process, hold_acknowledge,
    input  hold_request, dma_acknowledge_internal, dma_acknowledge, dma_rotate, service_start
  );

  modport slave (
    input  internal_data_bus, write_command_register, master_clear, transfer_mode,
           encoded_dma, dma_request_pending, cycle_done, end_of_process, hold_acknowledge,
    output hold_request, dma_acknowledge_internal, dma_acknowledge, dma_rotate, service_start
  );
endinterface

// File: rtl/kf8237_acknowledge_controller.sv
// HRQ/HLDA handshake, channel latch, DACK generation and priority rotation.
// All state advances on the falling edge of clock.
module kf8237_acknowledge_controller
  import kf8237_acknowledge_controller_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset_n,
  kf8237_acknowledge_controller_if.slave bus
);

  ack_state_t     state_q, state_d;
  logic [1:0]     ch_q, ch_d;
  logic [3:0]     ack_q, ack_d;
  logic [1:0]     rot_q, rot_d;
  logic           pol_q, pol_d;
  logic           start_q, start_d;
  logic           mode_release;
  transfer_mode_t ch_mode;
  logic           ch_pending;

  assign ch_mode    = bus.transfer_mode[ch_q];
  assign ch_pending = bus.dma_request_pending[ch_q];

  always_comb begin
    mode_release = 1'b0;
    unique case (ch_mode)
      SINGLE:  mode_release = bus.cycle_done;
      BLOCK:   mode_release = 1'b0;
      DEMAND:  mode_release = bus.cycle_done && !ch_pending;
      CASCADE: mode_release = !ch_pending;
      default: mode_release = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ack_d   = ack_q;
    rot_d   = rot_q;
    pol_d   = pol_q;
    start_d = 1'b0;

    if (bus.write_command_register) pol_d = bus.internal_data_bus[7];

    unique case (state_q)
      IDLE: if (bus.encoded_dma != 4'd0) state_d = REQUEST;
      REQUEST: begin
        if (bus.encoded_dma == 4'd0) begin
          state_d = IDLE;
        end else if (bus.hold_acknowledge) begin
          state_d = SERVICE;
          ch_d    = onehot_to_index(bus.encoded_dma);
          ack_d   = 4'b0001 << onehot_to_index(bus.encoded_dma);
          start_d = 1'b1;
        end
      end
      SERVICE: begin
        // Losing HLDA is an abort: the channel gave up nothing, so no rotation.
        if (!bus.hold_acknowledge) begin
          state_d = IDLE;
          ack_d   = 4'd0;
        end else if (bus.end_of_process || mode_release) begin
          state_d = RELEASE;
          ack_d   = 4'd0;
          rot_d   = ch_q + 2'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.master_clear) begin
      state_d = IDLE;
      ch_d    = 2'd0;
      ack_d   = 4'd0;
      rot_d   = 2'd0;
      pol_d   = 1'b0;
      start_d = 1'b0;
    end
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= 2'd0;
      ack_q   <= 4'd0;
      rot_q   <= 2'd0;
      pol_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ack_q   <= ack_d;
      rot_q   <= rot_d;
      pol_q   <= pol_d;
      start_q <= start_d;
    end
  end

  assign bus.hold_request             = (state_q == REQUEST) || (state_q == SERVICE);
  assign bus.dma_acknowledge_internal = ack_q;
  assign bus.dma_acknowledge          = pol_q ? ack_q : ~ack_q;
  assign bus.dma_rotate               = rot_q;
  assign bus.service_start            = start_q;

endmodule
